// File: rtl/multi_bank_mem_ctrl.sv
// multi_bank_mem_ctrl
// Maps a window of the CPU address space onto NUM_BANKS external memory
// banks. Each request is captured in IDLE, held in a fixed-length ACCESS
// phase of WAIT_STATES+1 cycles, and completed with a one-cycle RESP pulse.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cpu_addr/write_data   request address and write data
//   cpu_read_en/write_en  level request enables (write wins when both high)
//   cpu_read_data         registered read result
//   cpu_ready             one-cycle completion pulse
//   cpu_error             out-of-range flag, valid with cpu_ready
//   mem_read_data         per-bank read data, bank k at [k*DATA_WIDTH +: DATA_WIDTH]
//   mem_addr              in-bank word address, shared
//   mem_write_data        write data, shared
//   mem_chip_en           one-hot bank enable
//   mem_write_en          write strobe, shared
//
// Build option: MEMCTRL_ERR_RESP_EN
//   defined   : out-of-range completions raise cpu_error with cpu_ready
//   undefined : cpu_error tied 0, out-of-range reads return 0
//
// state  | meaning
// IDLE   | waiting for a request; captures address/data/operation
// ACCESS | bank selected for WAIT_STATES+1 cycles
// RESP   | cpu_ready pulse, then back to IDLE

module multi_bank_mem_ctrl #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE_ADDR  = 16'h1000,
  parameter int                    BANK_ADDR_BITS = 11,
  parameter int                    NUM_BANKS      = 2,
  parameter int                    WAIT_STATES    = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [ADDR_WIDTH-1:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0]           cpu_write_data,
  input  logic                            cpu_read_en,
  input  logic                            cpu_write_en,
  output logic [DATA_WIDTH-1:0]           cpu_read_data,
  output logic                            cpu_ready,
  output logic                            cpu_error,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_read_data,
  output logic [BANK_ADDR_BITS-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_write_data,
  output logic [NUM_BANKS-1:0]            mem_chip_en,
  output logic                            mem_write_en
);

  localparam int BANK_SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  // One extra bit so the window end can sit exactly at 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, MEM_BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LIMIT_EXT =
    BASE_EXT + ((ADDR_WIDTH+1)'(NUM_BANKS) << BANK_ADDR_BITS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state, state_next;
  logic [3:0]              wait_cnt;
  logic                    is_write_q;
  logic [BANK_SEL_W-1:0]   bank_q;
  logic [BANK_SEL_W-1:0]   bank_sel;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH:0]     addr_ext;
  logic                    in_range;
  logic                    req;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  assign req       = cpu_read_en | cpu_write_en;
  assign addr_ext  = {1'b0, cpu_addr};
  assign in_range  = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
  assign offset    = cpu_addr - MEM_BASE_ADDR;
  assign bank_sel  = BANK_SEL_W'(offset >> BANK_ADDR_BITS);
  assign sel_rdata = mem_read_data[bank_q*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = in_range ? ACCESS : RESP;
      ACCESS:  if (wait_cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef MEMCTRL_ERR_RESP_EN
  logic err_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt       <= 4'd0;
      is_write_q     <= 1'b0;
      bank_q         <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      cpu_read_data  <= '0;
`ifdef MEMCTRL_ERR_RESP_EN
      err_q          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            mem_addr       <= cpu_addr[BANK_ADDR_BITS-1:0];
            mem_write_data <= cpu_write_data;
            is_write_q     <= cpu_write_en;
            bank_q         <= bank_sel;
            wait_cnt       <= in_range ? 4'(WAIT_STATES) : 4'd0;
`ifdef MEMCTRL_ERR_RESP_EN
            err_q          <= !in_range;
`else
            // Out-of-range reads complete with a zero result.
            if (!in_range && !cpu_write_en) cpu_read_data <= '0;
`endif
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            if (!is_write_q) cpu_read_data <= sel_rdata;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ready    = (state == RESP);
  assign mem_chip_en  = (state == ACCESS) ? (NUM_BANKS'(1) << bank_q) : '0;
  assign mem_write_en = (state == ACCESS) && is_write_q;

`ifdef MEMCTRL_ERR_RESP_EN
  assign cpu_error = (state == RESP) && err_q;
`else
  assign cpu_error = 1'b0;
`endif

endmodule

// File: tb/tb_multi_bank_mem_ctrl.sv
// Testbench for multi_bank_mem_ctrl (default parameters). Expected
// completions are queued when a request is issued and compared when
// cpu_ready is seen. Bank memories are modelled as a fixed pattern of
// bank index and in-bank address.

module tb_multi_bank_mem_ctrl;

  localparam int          DW   = 8;
  localparam int          AW   = 16;
  localparam int          BAB  = 11;
  localparam int          NB   = 2;
  localparam int          WS   = 1;
  localparam logic [15:0] BASE = 16'h1000;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [AW-1:0]  cpu_addr = '0;
  logic [DW-1:0]  cpu_write_data = '0;
  logic           cpu_read_en = 1'b0;
  logic           cpu_write_en = 1'b0;
  logic [DW-1:0]  cpu_read_data;
  logic           cpu_ready;
  logic           cpu_error;
  logic [NB*DW-1:0] mem_read_data;
  logic [BAB-1:0] mem_addr;
  logic [DW-1:0]  mem_write_data;
  logic [NB-1:0]  mem_chip_en;
  logic           mem_write_en;

  always #5 clk = ~clk;

  multi_bank_mem_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_BASE_ADDR(BASE),
    .BANK_ADDR_BITS(BAB), .NUM_BANKS(NB), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready), .cpu_error(cpu_error),
    .mem_read_data(mem_read_data), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_chip_en(mem_chip_en),
    .mem_write_en(mem_write_en)
  );

  function automatic logic [7:0] bank_pat(input int k, input logic [BAB-1:0] a);
    return a[7:0] ^ 8'(8'h39 * k);
  endfunction

  always_comb begin
    mem_read_data = '0;
    for (int k = 0; k < NB; k++) mem_read_data[k*DW +: DW] = bank_pat(k, mem_addr);
  end

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && cpu_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_ready", 32'(cpu_ready), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rdata", 32'(cpu_read_data), 32'(e.rdata));
        check("error", 32'(cpu_error), 32'(e.err));
      end
    end
  end

  // Builds the expected completion and updates the read-data model.
  function automatic exp_t predict(input logic [15:0] addr, input logic rd, input logic wr);
    exp_t e;
    int   a;
    logic inr;
    a   = int'(addr);
    inr = (a >= int'(BASE)) && (a < int'(BASE) + (NB << BAB));
    e.err = 1'b0;
    if (!wr && rd) begin
      if (inr) model_rdata = bank_pat((a - int'(BASE)) >> BAB, addr[BAB-1:0]);
      else begin
`ifdef MEMCTRL_ERR_RESP_EN
        e.err = 1'b1;
`else
        model_rdata = 8'h00;
`endif
      end
    end else if (!inr) begin
`ifdef MEMCTRL_ERR_RESP_EN
      e.err = 1'b1;
`endif
    end
    e.rdata = model_rdata;
    return e;
  endfunction

  task automatic run_req(input logic [15:0] addr, input logic [7:0] wd,
                         input logic rd, input logic wr, input bit no_wait);
    int            a;
    logic          inr;
    logic [NB-1:0] exp_ce;
    int            cyc;
    exp_t          e;
    a      = int'(addr);
    inr    = (a >= int'(BASE)) && (a < int'(BASE) + (NB << BAB));
    exp_ce = inr ? (NB'(1) << ((a - int'(BASE)) >> BAB)) : '0;
    e      = predict(addr, rd, wr);
    if (!no_wait) @(negedge clk);
    cpu_addr       = addr;
    cpu_write_data = wd;
    cpu_read_en    = rd;
    cpu_write_en   = wr;
    @(posedge clk);
    sb_q.push_back(e);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) break;
      check("chip_en", 32'(mem_chip_en), 32'(exp_ce));
      check("mem_we", 32'(mem_write_en), 32'(wr));
      check("mem_addr", 32'(mem_addr), 32'(addr[BAB-1:0]));
      if (wr) check("mem_wdata", 32'(mem_write_data), 32'(wd));
      check("error_idle", 32'(cpu_error), 32'd0);
    end
    cpu_read_en  = 1'b0;
    cpu_write_en = 1'b0;
    check("latency", 32'(cyc), inr ? 32'(WS + 2) : 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c1, c2;
    exp_t e;
    logic [15:0] ra;
    int   op;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rdata", 32'(cpu_read_data), 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_error", 32'(cpu_error), 32'd0);
    check("rst_chip_en", 32'(mem_chip_en), 32'd0);
    check("rst_mem_we", 32'(mem_write_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_write_data), 32'd0);

    // First request accepted in the first cycle after release
    @(negedge clk);
    reset_n = 1'b1;
    run_req(16'h1805, 8'h00, 1'b1, 1'b0, 1'b1);

    run_req(16'h1004, 8'hA5, 1'b0, 1'b1, 1'b0);
    run_req(16'h1004, 8'h00, 1'b1, 1'b0, 1'b0);
    run_req(16'h2000, 8'h00, 1'b1, 1'b0, 1'b0);
    run_req(16'h1FFF, 8'h00, 1'b1, 1'b0, 1'b0);
    run_req(16'h0FFF, 8'h00, 1'b1, 1'b0, 1'b0);
    run_req(16'h1000, 8'h00, 1'b1, 1'b0, 1'b0);
    run_req(16'h17FF, 8'h00, 1'b1, 1'b0, 1'b0);
    run_req(16'h1800, 8'h00, 1'b1, 1'b0, 1'b0);
    run_req(16'h3000, 8'h5A, 1'b0, 1'b1, 1'b0);
    run_req(16'h1010, 8'h77, 1'b1, 1'b1, 1'b0);

    // Enable held through completion: next transaction starts right after RESP
    @(negedge clk);
    e = predict(16'h1001, 1'b1, 1'b0);
    sb_q.push_back(e);
    sb_q.push_back(e);
    cpu_addr    = 16'h1001;
    cpu_read_en = 1'b1;
    @(posedge clk);
    c1 = 0;
    c2 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        if (c1 == 0) c1 = i;
        else begin
          c2 = i;
          break;
        end
      end
    end
    cpu_read_en = 1'b0;
    check("b2b_first", 32'(c1), 32'(WS + 2));
    check("b2b_gap", 32'(c2 - c1), 32'(WS + 3));

    // Mixed traffic around the window edges
    for (int n = 0; n < 16; n++) begin
      ra = 16'($urandom_range(32'h0F00, 32'h2100));
      op = int'($urandom_range(0, 2));
      run_req(ra, 8'($urandom), (op != 1), (op != 0), 1'b0);
    end

    // Reset in the first ACCESS cycle aborts the read
    @(negedge clk);
    cpu_addr    = 16'h1805;
    cpu_read_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_pre_chip_en", 32'(mem_chip_en), 32'h2);
    reset_n     = 1'b0;
    cpu_read_en = 1'b0;
    model_rdata = 8'h00;
    #1;
    check("abort_chip_en", 32'(mem_chip_en), 32'd0);
    check("abort_rdata", 32'(cpu_read_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    c1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_ready) c1++;
    end
    check("abort_no_ready", 32'(c1), 32'd0);

    run_req(16'h1805, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
